player_life_ctrl: RTL

PLAYER_LIFE_CTRL -- requirements
Module: player_life_ctrl

---
 rtl/game_pkg.sv | 14 +
 rtl/invuln_timer.sv | 36 +++
 rtl/player_life_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the life-control blocks (player, enemy, boss).
// Holds the life FSM state encoding so every life block decodes the same
// values.
package game_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    DEAD   = 2'd2
  } life_state_t;

endpackage

// File: rtl/invuln_timer.sv
// Post-hit invulnerability timer.
// Counts up from 0 while enabled. tc flags the last cycle of the window
// (cnt == INVULN_CYCLES-1), and the counter returns to 0 on that edge.
//   clk_22 : clock
//   rst_n  : synchronous active-low reset
//   clr    : force the count to 0 (wins over en)
//   en     : advance the count by one this cycle
//   cnt    : current count
//   tc     : terminal-count flag, only asserted while en is high
module invuln_timer #(
  parameter  int INVULN_CYCLES = 64,
  localparam int CNT_W         = $clog2(INVULN_CYCLES + 1)
) (
  input  logic             clk_22,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(INVULN_CYCLES - 1);

  assign tc = en && (cnt == LAST);

  always_ff @(posedge clk_22) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tc) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/player_life_ctrl.sv
// Player life controller: tracks remaining lives, grants a timed
// invulnerability window after each hit, and holds in DEAD until a continue.
//   clk_22    : clock
//   rst_n     : synchronous active-low reset
//   hit       : player struck this cycle (level-sampled)
//   extend    : extra-life award this cycle
//   cont      : continue request, only honoured in DEAD
//   life      : remaining lives (registered)
//   visible   : sprite enable (blinks while invulnerable)
//   invuln    : high in INVULN
//   game_over : high in DEAD
//   hit_ack   : one-cycle pulse per accepted hit
//
// state  | meaning
// -------+------------------------------------------------------------
// ALIVE  | vulnerable; a hit costs a life
// INVULN | post-hit / post-continue grace window, hits ignored
// DEAD   | no lives left; waits for cont, life held at 0
module player_life_ctrl
  import game_pkg::*;
#(
  parameter  int MAX_LIFE      = 3,
  parameter  int INIT_LIFE     = 3,
  parameter  int INVULN_CYCLES = 64,
  parameter  int BLINK_SHIFT   = 3,
  localparam int LIFE_W        = $clog2(MAX_LIFE + 1),
  localparam int CNT_W         = $clog2(INVULN_CYCLES + 1)
) (
  input  logic              clk_22,
  input  logic              rst_n,
  input  logic              hit,
  input  logic              extend,
  input  logic              cont,
  output logic [LIFE_W-1:0] life,
  output logic              visible,
  output logic              invuln,
  output logic              game_over,
  output logic              hit_ack
);

  localparam logic [LIFE_W-1:0] LIFE_MAX  = LIFE_W'(MAX_LIFE);
  localparam logic [LIFE_W-1:0] LIFE_INIT = LIFE_W'(INIT_LIFE);
  // Mask form of cnt[BLINK_SHIFT]; evaluates to 0 (never lit) when the
  // timer is too short to reach that bit.
  localparam logic [CNT_W-1:0]  BLINK_MASK = CNT_W'(1) << BLINK_SHIFT;

  life_state_t       state;
  logic [CNT_W-1:0]  cnt;
  logic              tc;
  logic              blink;
  logic [LIFE_W-1:0] life_dec;
  logic [LIFE_W-1:0] life_inc;
  logic [LIFE_W-1:0] life_dec_inc;

  // Counter sits at 0 outside INVULN, so every entry starts from 0.
  invuln_timer #(
    .INVULN_CYCLES(INVULN_CYCLES)
  ) u_timer (
    .clk_22(clk_22),
    .rst_n (rst_n),
    .clr   (state != INVULN),
    .en    (state == INVULN),
    .cnt   (cnt),
    .tc    (tc)
  );

  // Saturating arithmetic; hit+extend is decrement-then-increment so a
  // full life bar stays full.
  assign life_dec     = (life == '0) ? '0 : life - LIFE_W'(1);
  assign life_inc     = (life >= LIFE_MAX) ? LIFE_MAX : life + LIFE_W'(1);
  assign life_dec_inc = (life_dec >= LIFE_MAX) ? LIFE_MAX : life_dec + LIFE_W'(1);

  always_ff @(posedge clk_22) begin
    if (!rst_n) begin
      state   <= ALIVE;
      life    <= LIFE_INIT;
      hit_ack <= 1'b0;
    end else begin
      hit_ack <= 1'b0;
      case (state)
        ALIVE: begin
          if (hit) begin
            hit_ack <= 1'b1;
            if (extend) begin
              life  <= life_dec_inc;
              state <= INVULN;
            end else begin
              life  <= life_dec;
              state <= (life_dec == '0) ? DEAD : INVULN;
            end
          end else if (extend) begin
            life <= life_inc;
          end
        end
        INVULN: begin
          if (extend) life <= life_inc;
          if (tc) state <= ALIVE;
        end
        DEAD: begin
          if (cont) begin
            life  <= LIFE_INIT;
            state <= INVULN;
          end else begin
            life <= '0;
          end
        end
        default: state <= ALIVE;
      endcase
    end
  end

  assign blink     = |(cnt & BLINK_MASK);
  assign visible   = (state == ALIVE) || ((state == INVULN) && blink);
  assign invuln    = (state == INVULN);
  assign game_over = (state == DEAD);

endmodule
